// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver slice.
// Break detection is enabled with UART_RX_BREAK_DETECT_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_t;

  localparam int DATA_BITS    = 8;
  localparam int MIN_BAUD_DIV = 4;

  typedef struct packed {
    logic       parity_ok;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic even_par_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ~(^d ^ p);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Processor-side read port of the UART receiver.
// Master pops bytes; slave presents the fall-through head.
interface uart_rx_core_if;
  import uart_pkg::*;

  logic       rd_en;
  logic [7:0] data_out;
  logic       valid_out;
  logic       parity_ok;

  modport master (
    output rd_en,
    input  data_out,
    input  valid_out,
    input  parity_ok
  );

  modport slave (
    input  rd_en,
    output data_out,
    output valid_out,
    output parity_ok
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO for received UART entries.
// Reports a one-cycle overrun when a write is dropped.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      wr_en,
  input  rx_entry_t wr_data,
  input  logic      rd_en,
  output rx_entry_t head,
  output logic      empty,
  output logic      full,
  output logic      overrun
);

  localparam int AW = $clog2(DEPTH);

  rx_entry_t      mem_q [DEPTH];
  rx_entry_t      mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [7:0]     last_q, last_d;
  logic           ovr_q, ovr_d;
  logic           push, pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign overrun = ovr_q;

  // Once drained, keep showing the byte that was last popped.
  assign head = empty
    ? rx_entry_t'{parity_ok: 1'b1, data: last_q}
    : mem_q[rd_ptr_q];

  always_comb begin
    pop      = rd_en & ~empty;
    push     = wr_en & (~full | pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    ovr_d    = wr_en & full & ~pop;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q].data;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      ovr_q    <= ovr_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchroniser, bit FSM and receive FIFO.
// Optional break detection: define UART_RX_BREAK_DETECT_EN.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx_in,
  input  logic           rx_en,
  input  logic           parity_sel,
  input  logic           stop_sel,
  input  logic [11:0]    baud_divisor,
  uart_rx_core_if.slave  rd_if,
  output logic           frame_err,
  output logic           overrun,
  output logic           break_det
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  rx_state_t              state_q, state_d;
  logic [11:0]            cnt_q, cnt_d;
  logic [11:0]            div_q, div_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_en_q, par_en_d;
  logic                   stop2_q, stop2_d;
  logic                   pok_q, pok_d;
  logic                   wr_q, wr_d;
  logic                   fe_q, fe_d;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                   brk_q, brk_d;
  logic                   brk_wait_q, brk_wait_d;
`endif

  logic      rx_s;
  logic      fall;
  logic      mid;
  logic      wrap;
  rx_entry_t head;
  logic      empty;
  logic      full;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev_q & ~rx_s;
  assign mid  = (cnt_q == (div_q >> 1));
  assign wrap = (cnt_q == div_q - 12'd1);

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rx_in};
    rx_prev_d = rx_s;
    state_d   = state_q;
    cnt_d     = wrap ? '0 : cnt_q + 12'd1;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    pok_d     = pok_q;
    wr_d      = 1'b0;
    fe_d      = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    brk_d      = 1'b0;
    brk_wait_d = brk_wait_q;
`endif
    if (!rx_en) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_wait_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
`ifdef UART_RX_BREAK_DETECT_EN
          // After a break, need one full high bit period before rearming.
          if (brk_wait_q) begin
            if (!rx_s) begin
              cnt_d = '0;
            end else if (wrap) begin
              brk_wait_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 12'd1;
            end
          end else
`endif
          if (fall) begin
            state_d  = START;
            div_d    = baud_divisor;
            par_en_d = parity_sel;
            stop2_d  = stop_sel;
            bit_d    = '0;
            pok_d    = 1'b1;
          end
        end
        START: begin
          if (mid) begin
            state_d = rx_s ? IDLE : DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (mid) begin
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'(DATA_BITS - 1)) begin
              state_d = par_en_q ? PARITY : STOP1;
            end
          end
        end
        PARITY: begin
          if (mid) begin
            pok_d   = even_par_ok(shift_q, rx_s);
            state_d = STOP1;
          end
        end
        STOP1: begin
          if (mid) begin
            if (!rx_s) begin
              state_d = IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
              // All-zero data with even parity means the parity bit was 0.
              if (shift_q == '0 && pok_q) begin
                brk_d      = 1'b1;
                brk_wait_d = 1'b1;
              end else begin
                fe_d = 1'b1;
              end
`else
              fe_d = 1'b1;
`endif
            end else if (stop2_q) begin
              state_d = STOP2;
            end else begin
              wr_d    = 1'b1;
              state_d = IDLE;
            end
          end
        end
        STOP2: begin
          if (mid) begin
            state_d = IDLE;
            wr_d    = rx_s;
            fe_d    = ~rx_s;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      pok_q     <= 1'b1;
      wr_q      <= 1'b0;
      fe_q      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_q      <= 1'b0;
      brk_wait_q <= 1'b0;
`endif
    end else begin
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      pok_q     <= pok_d;
      wr_q      <= wr_d;
      fe_q      <= fe_d;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_q      <= brk_d;
      brk_wait_q <= brk_wait_d;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_q),
    .wr_data (rx_entry_t'{parity_ok: pok_q, data: shift_q}),
    .rd_en   (rd_if.rd_en),
    .head    (head),
    .empty   (empty),
    .full    (full),
    .overrun (overrun)
  );

  assign rd_if.data_out  = head.data;
  assign rd_if.parity_ok = head.parity_ok;
  assign rd_if.valid_out = ~empty;
  assign frame_err       = fe_q;

`ifdef UART_RX_BREAK_DETECT_EN
  assign break_det = brk_q;
`else
  assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core.
// Break checks follow UART_RX_BREAK_DETECT_EN.
module tb_uart_rx_core;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_in = 1'b1;
  logic        rx_en = 1'b0;
  logic        parity_sel = 1'b0;
  logic        stop_sel = 1'b0;
  logic [11:0] div = 12'd16;
  logic        frame_err, overrun, break_det;

  uart_rx_core_if rif();

  uart_rx_core #(
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_en        (rx_en),
    .parity_sel   (parity_sel),
    .stop_sel     (stop_sel),
    .baud_divisor (div),
    .rd_if        (rif.slave),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .break_det    (break_det)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int brk_cnt = 0;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (break_det === 1'b1) brk_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit pen,
                      input logic pbit, input logic s1,
                      input bit two, input logic s2,
                      input bit chk_lat);
    logic bv [12];
    int   nb;
    int   edges;
    bv[0] = 1'b0;
    for (int i = 0; i < 8; i++) bv[i+1] = d[i];
    nb = 9;
    if (pen) begin bv[nb] = pbit; nb++; end
    bv[nb] = s1; nb++;
    if (two) begin bv[nb] = s2; nb++; end
    edges = 0;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      rx_in = bv[i];
      repeat (int'(div)) begin
        @(posedge clk);
        edges++;
        if (chk_lat && edges == 156) begin
          #1 check("lat_pre", rif.valid_out, 0);
        end
        if (chk_lat && edges == 157) begin
          #1 check("lat_post", rif.valid_out, 1);
        end
      end
    end
    @(negedge clk);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rif.rd_en = 1'b1;
    @(negedge clk);
    rif.rd_en = 1'b0;
  endtask

  int fe0;

  initial begin
    rif.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", rif.valid_out, 0);
    check("rst_data", rif.data_out, 0);
    check("rst_pok", rif.parity_ok, 1);
    check("rst_fe", frame_err, 0);
    check("rst_ov", overrun, 0);
    check("rst_brk", break_det, 0);
    reset = 1'b1;
    rx_en = 1'b1;
    repeat (4) @(negedge clk);

    send(8'hA5, 0, 0, 1, 0, 1, 1);
    check("a5_data", rif.data_out, 8'hA5);
    check("a5_pok", rif.parity_ok, 1);
    check("a5_fe", fe_cnt, 0);
    pop();
    check("a5_pop_valid", rif.valid_out, 0);
    check("empty_pok", rif.parity_ok, 1);
    check("empty_hold", rif.data_out, 8'hA5);

    parity_sel = 1'b1;
    send(8'h03, 1, 1, 1, 0, 1, 0);
    check("p03_bad_data", rif.data_out, 8'h03);
    check("p03_bad_pok", rif.parity_ok, 0);
    check("p03_bad_fe", fe_cnt, 0);
    pop();
    send(8'h03, 1, 0, 1, 0, 1, 0);
    check("p03_good_pok", rif.parity_ok, 1);
    pop();
    send(8'h07, 1, 1, 1, 0, 1, 0);
    check("p07_good_data", rif.data_out, 8'h07);
    check("p07_good_pok", rif.parity_ok, 1);
    pop();
    parity_sel = 1'b0;

    stop_sel = 1'b1;
    send(8'h5A, 0, 0, 1, 1, 0, 0);
    check("stop2_fe", fe_cnt, 1);
    check("stop2_valid", rif.valid_out, 0);
    send(8'h5A, 0, 0, 1, 1, 1, 0);
    check("stop2_ok_valid", rif.valid_out, 1);
    check("stop2_ok_data", rif.data_out, 8'h5A);
    pop();
    stop_sel = 1'b0;
    send(8'h81, 0, 0, 0, 0, 1, 0);
    check("stop1_fe", fe_cnt, 2);
    check("stop1_valid", rif.valid_out, 0);

    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 0, 0, 1, 0, 1, 0);
    end
    check("ovr_cnt", ov_cnt, 1);
    check("ovr_valid", rif.valid_out, 1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_rd%0d", i), rif.data_out, i);
      pop();
    end
    check("ovr_drained", rif.valid_out, 0);

    div = 12'd4;
    send(8'h3C, 0, 0, 1, 0, 1, 0);
    check("div4_data", rif.data_out, 8'h3C);
    pop();
    div = 12'd16;

    fe0 = fe_cnt;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_state", dut.state_q, IDLE);
    check("glitch_fe", fe_cnt, fe0);
    check("glitch_valid", rif.valid_out, 0);

    fork
      send(8'hFF, 0, 0, 1, 0, 1, 0);
      begin
        repeat (84) @(negedge clk);
        rx_en = 1'b0;
        @(negedge clk);
        check("dis_state", dut.state_q, IDLE);
      end
    join
    rx_en = 1'b1;
    repeat (4) @(negedge clk);
    check("dis_valid", rif.valid_out, 0);
    check("dis_fe", fe_cnt, fe0);

    send(8'h11, 0, 0, 1, 0, 1, 0);
    check("pre_rst_valid", rif.valid_out, 1);
    fork
      send(8'h00, 0, 0, 1, 0, 1, 0);
      begin
        repeat (60) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", rif.valid_out, 0);
        check("mid_rst_data", rif.data_out, 0);
        check("mid_rst_pok", rif.parity_ok, 1);
        check("mid_rst_fe", frame_err, 0);
        check("mid_rst_state", dut.state_q, IDLE);
      end
    join
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_valid", rif.valid_out, 0);
    check("post_rst_fe", fe_cnt, fe0);

    fe0 = fe_cnt;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (16 * 12) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
    check("brk_cnt", brk_cnt, 1);
    check("brk_fe", fe_cnt, fe0);
`else
    check("brk_cnt", brk_cnt, 0);
    check("brk_fe", fe_cnt, fe0 + 1);
`endif
    check("brk_valid", rif.valid_out, 0);

    send(8'h42, 0, 0, 1, 0, 1, 0);
    check("after_brk_data", rif.data_out, 8'h42);
    check("after_brk_valid", rif.valid_out, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Standalone UART receiver. It deserialises the line driven by the team's UART transmitter, checks parity and stop bits, and buffers received bytes in a small FIFO. The processor side reads bytes with a first-word-fall-through interface. It is the far end of the serial link and replaces the direct tx-to-rx loopback when the UART talks to an external device.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
SYNC_STAGES, 2, flops in the rx_in metastability synchroniser; minimum 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_in  in  1  serial line, idle high
rx_en  in  1  receiver enable
parity_sel  in  1  1 = even-parity bit follows the data; 0 = no parity bit
stop_sel  in  1  0 = one stop bit; 1 = two stop bits
baud_divisor  in  12  clocks per bit period; legal values >= 4
rd_en  in  1  pop the FIFO head
data_out  out  8  FIFO head byte
valid_out  out  1  FIFO not empty
parity_ok  out  1  parity status stored with the head byte
frame_err  out  1  one-cycle pulse: a stop bit was sampled low
overrun  out  1  one-cycle pulse: a byte was dropped because the FIFO was full
break_det  out  1  one-cycle pulse: break detected (optional feature only)

Behaviour:
- Reset (reset=0, asynchronous):
  - synchroniser flops = 1; FSM = IDLE; bit counter and baud counter = 0.
  - FIFO empty; data_out = 0; valid_out = 0; parity_ok = 1.
  - frame_err = 0; overrun = 0; break_det = 0.
  - Reset mid-frame discards the partial byte.
- Sampling:
  - The baud counter counts 0..baud_divisor-1 and wraps.
  - Bits are sampled when count == baud_divisor>>1, the mid-bit point.
  - The counter restarts at 0 on the falling edge that starts a frame.
  - baud_divisor is captured at frame start; changes mid-frame are ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE -> START: on a synchronised 1->0 transition while rx_en=1.
  - START: at mid-bit, line=0 -> DATA; line=1 -> IDLE (false start, nothing reported).
  - DATA: 8 samples, LSB first, into the shift register. After bit 7 -> PARITY if parity_sel=1, else STOP1.
  - PARITY: sample the parity bit. parity_ok_int = (^data ^ bit) == 0 (even parity). -> STOP1.
  - STOP1: sample the stop bit.
    - Line=0: frame_err pulses, the byte is not written, -> IDLE.
    - Line=1: -> STOP2 if stop_sel=1, else write the byte and go -> IDLE.
  - STOP2: line=0 -> frame_err pulse, no write. Line=1 -> write. Either way -> IDLE.
  - parity_sel and stop_sel are captured at frame start.
- rx_en=0: the FSM is forced to IDLE on the next clock, aborting any frame with no flags raised. The FIFO and its read side stay operational.
- Write latency:
  - The FIFO write occurs on the clock edge after the final stop-bit mid sample.
  - valid_out rises on that same edge when the FIFO was empty.
  - Each entry stores {parity_ok_int, byte}; parity_ok_int = 1 when parity_sel=0.
- Read side:
  - data_out and parity_ok always show the head entry (fall-through).
  - rd_en while valid_out=1 pops on the clock edge.
  - rd_en while empty is ignored.
  - When empty, data_out holds its last value and parity_ok = 1.
- Full / simultaneous events:
  - Write while full with no rd_en: the new byte is dropped and overrun pulses.
  - Write and pop in the same cycle while full: both are performed, no overrun, count unchanged.
  - Write and pop in the same cycle while count=1: the entry is replaced, valid_out stays 1.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined:
  - A frame whose data bits are all 0, whose parity bit (if present) is 0, and whose first stop bit is 0 raises break_det for one cycle instead of frame_err.
  - The FSM then stays in IDLE until the line has been high for one full bit period.
- Not defined:
  - Such a frame is an ordinary framing error.
  - break_det is tied to 0.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP1, STOP2)
  - DATA_BITS = 8
  - MIN_BAUD_DIV = 4
  - typedef rx_entry_t {logic parity_ok; logic [7:0] data;}
- Sub-module uart_rx_fifo: parameterised by DEPTH; handles write, read, count, full and empty; stores rx_entry_t.

Test Plan:
- baud_divisor=16, parity_sel=0, stop_sel=0, send 0xA5 -> valid_out=1 one clock after the stop mid-sample; data_out=0xA5; parity_ok=1; rd_en for 1 cycle -> valid_out=0.
- parity_sel=1, send 0x03 with parity bit 1 (wrong, even parity expects 0) -> data_out=0x03, parity_ok=0, no frame_err.
- stop_sel=1, second stop bit driven 0 on 0x5A -> frame_err pulses once, valid_out stays 0.
- 5 frames 0x01..0x05, DEPTH=4, no reads -> overrun pulses once on the 5th; reads return 0x01..0x04.
- Glitch low for 3 clocks (baud_divisor=16) -> false start, no flags, FSM back to IDLE; then deassert rx_en during bit 4 of 0xFF -> no write, no flags; then reset mid-frame -> all outputs at reset values.
- With UART_RX_BREAK_DETECT_EN: line held low for 12 bit periods -> break_det pulses once, frame_err=0, no write.
